// File: rtl/mem_access_unit_if.sv
// Request/response and data_mem bus for mem_access_unit.
//  slave  : the load/store unit (mem_access_unit) side
//  master : the MEM-stage requester plus data_mem side
// Signals:
//  req_valid/req_ready/req_write/req_size/req_unsigned/req_addr/req_wdata
//                      request handshake and fields
//  resp_valid/resp_rdata/resp_err
//                      one-cycle completion report
//  mem_addr/mem_wdata/mem_we/mem_re/mem_rdata
//                      word-indexed data_mem port
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store controller between the MEM pipeline stage and data_mem.
// Takes one byte/half/word request at a time, converts the byte address to a
// word index and issues single-cycle, separated mem_re/mem_we pulses (data_mem
// acts on enable rising edges). Sub-word stores are read-modify-write; loads
// are sign- or zero-extended. Misaligned, illegal-size and out-of-range
// requests complete one cycle after acceptance with resp_err and no memory
// access.
// Ports:
//  clk    rising-edge clock
//  rst_n  asynchronous active-low reset
//  bus    mem_access_unit_if.slave: request handshake, response, data_mem port
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 32
) (
  input logic             clk,
  input logic             rst_n,
  mem_access_unit_if.slave bus
);

  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    WRITE,
    RESP
  } state_t;

  state_t      state, state_nxt;

  logic        write_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic        err_q;
  // Holds the SW store word from acceptance, then the merged word (sub-word
  // store) or the extended load result after CAPTURE.
  logic [31:0] data_q;

  logic        accept;
  logic        fault;
  logic [31:0] merged;
  logic [31:0] extended;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  assign accept = bus.req_valid && (state == IDLE);

  always_comb begin
    fault = 1'b0;
    if (bus.req_size == 2'b11)                               fault = 1'b1;
    if (bus.req_size == 2'b01 && bus.req_addr[0])            fault = 1'b1;
    if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) fault = 1'b1;
    if ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS_L)          fault = 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (fault)                      state_nxt = RESP;
          else if (!bus.req_write)        state_nxt = READ;
          else if (bus.req_size == 2'b10) state_nxt = WRITE;
          else                            state_nxt = READ;
        end
      end
      READ:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = write_q ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from state so enables fall immediately on reset.
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.mem_re     = (state == READ);
    bus.mem_we     = (state == WRITE);
    bus.resp_valid = (state == RESP);
    bus.resp_err   = (state == RESP) && err_q;
    bus.resp_rdata = ((state == RESP) && !write_q && !err_q) ? data_q : '0;
    bus.mem_wdata  = (state == WRITE) ? data_q : '0;
    bus.mem_addr   = {2'b00, addr_q[31:2]};
  end

  // Sub-word store merge: replace only the addressed lanes of the read word.
  always_comb begin
    merged = bus.mem_rdata;
    for (int unsigned i = 0; i < 4; i++) begin
      if (size_q == 2'b00 && 2'(i) == addr_q[1:0])
        merged[8*i +: 8] = wdata_q[7:0];
      if (size_q == 2'b01 && 1'(i >> 1) == addr_q[1])
        merged[8*i +: 8] = wdata_q[8*(i % 2) +: 8];
    end
  end

  // Load extraction and extension (little-endian lanes).
  always_comb begin
    byte_sh  = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    half_sh  = bus.mem_rdata >> {addr_q[1], 4'b0000};
    extended = bus.mem_rdata;
    case (size_q)
      2'b00:   extended = uns_q ? {24'h0, byte_sh[7:0]}
                                : {{24{byte_sh[7]}}, byte_sh[7:0]};
      2'b01:   extended = uns_q ? {16'h0, half_sh[15:0]}
                                : {{16{half_sh[15]}}, half_sh[15:0]};
      default: extended = bus.mem_rdata;
    endcase
  end

  // Request latch and data buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else if (accept) begin
      write_q <= bus.req_write;
      size_q  <= bus.req_size;
      uns_q   <= bus.req_unsigned;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata[15:0];
      err_q   <= fault;
      data_q  <= bus.req_write ? bus.req_wdata : '0;
    end else if (state == CAPTURE) begin
      data_q  <= write_q ? merged : extended;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_WORDS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // data_mem model: synchronous read and write on enable
  logic [31:0] mem [32];
  bit          mem_cleared = 1'b0;
  always @(posedge clk) begin
    if (!mem_cleared) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      bus.mem_rdata <= 32'h0;
      mem_cleared   <= 1'b1;
    end else begin
      if (bus.mem_re && bus.mem_addr < 32) bus.mem_rdata <= mem[bus.mem_addr[4:0]];
      if (bus.mem_we && bus.mem_addr < 32) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
    end
  end

  // Enable pulse monitor
  int unsigned re_cnt = 0, we_cnt = 0, overlap_cnt = 0;
  logic        re_prev = 1'b0, we_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.mem_re && !re_prev) re_cnt <= re_cnt + 1;
    if (bus.mem_we && !we_prev) we_cnt <= we_cnt + 1;
    if (bus.mem_re && bus.mem_we) overlap_cnt <= overlap_cnt + 1;
    re_prev <= bus.mem_re;
    we_prev <= bus.mem_we;
  end

  int unsigned total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int unsigned lat;
    int unsigned nre;
    int unsigned nwe;
    int unsigned chk_idx;
    logic [31:0] chk_val;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata,
                              input int unsigned lat, input int unsigned nre,
                              input int unsigned nwe, input int unsigned chk_idx,
                              input logic [31:0] chk_val);
    vec_t v;
    v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.lat = lat; v.nre = nre; v.nwe = nwe;
    v.chk_idx = chk_idx; v.chk_val = chk_val;
    return v;
  endfunction

  task automatic do_op(input string tag, input vec_t v);
    int unsigned re0, we0, lat;
    logic        got;
    logic [31:0] rdata;
    logic        err;
    got = 1'b0; lat = 0; rdata = '0; err = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_write    = v.wr;
    bus.req_size     = v.sz;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    @(posedge clk);
    re0 = re_cnt; we0 = we_cnt;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_valid = 1'b0;
        chk({tag, "_ready_busy"}, 32'(bus.req_ready), 32'd0);
      end
      if (bus.resp_valid) begin
        got = 1'b1; lat = c; rdata = bus.resp_rdata; err = bus.resp_err;
        break;
      end
    end
    #1;
    chk({tag, "_resp_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_err"}, 32'(err), 32'(v.err));
    chk({tag, "_rdata"}, rdata, v.rdata);
    chk({tag, "_re_pulses"}, re_cnt - re0, v.nre);
    chk({tag, "_we_pulses"}, we_cnt - we0, v.nwe);
    chk({tag, "_mem_word"}, mem[v.chk_idx], v.chk_val);
    @(negedge clk);
    chk({tag, "_resp_one_cycle"}, 32'(bus.resp_valid), 32'd0);
  endtask

  vec_t tbl[21];

  initial begin
    int unsigned seen_resp, we0;

    // Table: wr sz uns addr wdata | err rdata lat nre nwe chk_idx chk_val
    tbl[0]  = mk(1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 0, 32'h0,        2, 0, 1, 2,  32'hDEADBEEF);
    tbl[1]  = mk(0, 2'b10, 0, 32'h08, 32'h0,        0, 32'hDEADBEEF, 3, 1, 0, 2,  32'hDEADBEEF);
    tbl[2]  = mk(1, 2'b00, 0, 32'h09, 32'h00000055, 0, 32'h0,        4, 1, 1, 2,  32'hDEAD55EF);
    tbl[3]  = mk(0, 2'b00, 0, 32'h0B, 32'h0,        0, 32'hFFFFFFDE, 3, 1, 0, 2,  32'hDEAD55EF);
    tbl[4]  = mk(0, 2'b00, 1, 32'h0B, 32'h0,        0, 32'h000000DE, 3, 1, 0, 2,  32'hDEAD55EF);
    tbl[5]  = mk(0, 2'b01, 0, 32'h0A, 32'h0,        0, 32'hFFFFDEAD, 3, 1, 0, 2,  32'hDEAD55EF);
    tbl[6]  = mk(0, 2'b00, 0, 32'h08, 32'h0,        0, 32'hFFFFFFEF, 3, 1, 0, 2,  32'hDEAD55EF);
    tbl[7]  = mk(0, 2'b01, 1, 32'h08, 32'h0,        0, 32'h000055EF, 3, 1, 0, 2,  32'hDEAD55EF);
    tbl[8]  = mk(1, 2'b01, 0, 32'h0A, 32'hFFFF1234, 0, 32'h0,        4, 1, 1, 2,  32'h123455EF);
    tbl[9]  = mk(0, 2'b01, 0, 32'h0A, 32'h0,        0, 32'h00001234, 3, 1, 0, 2,  32'h123455EF);
    tbl[10] = mk(0, 2'b10, 0, 32'h06, 32'h0,        1, 32'h0,        1, 0, 0, 2,  32'h123455EF);
    tbl[11] = mk(1, 2'b01, 0, 32'h01, 32'hFFFFFFFF, 1, 32'h0,        1, 0, 0, 0,  32'h00000000);
    tbl[12] = mk(1, 2'b11, 0, 32'h08, 32'h00000000, 1, 32'h0,        1, 0, 0, 2,  32'h123455EF);
    tbl[13] = mk(0, 2'b10, 0, 32'h80, 32'h0,        1, 32'h0,        1, 0, 0, 0,  32'h00000000);
    tbl[14] = mk(1, 2'b10, 0, 32'h7C, 32'hA5A50001, 0, 32'h0,        2, 0, 1, 31, 32'hA5A50001);
    tbl[15] = mk(1, 2'b00, 0, 32'h7F, 32'h00000080, 0, 32'h0,        4, 1, 1, 31, 32'h80A50001);
    tbl[16] = mk(0, 2'b00, 0, 32'h7F, 32'h0,        0, 32'hFFFFFF80, 3, 1, 0, 31, 32'h80A50001);
    tbl[17] = mk(0, 2'b10, 0, 32'h7C, 32'h0,        0, 32'h80A50001, 3, 1, 0, 31, 32'h80A50001);
    tbl[18] = mk(0, 2'b01, 0, 32'h7E, 32'h0,        0, 32'hFFFF80A5, 3, 1, 0, 31, 32'h80A50001);
    tbl[19] = mk(1, 2'b00, 0, 32'h08, 32'hAAAAAA00, 0, 32'h0,        4, 1, 1, 2,  32'h12345500);
    tbl[20] = mk(1, 2'b10, 0, 32'h84, 32'h11111111, 1, 32'h0,        1, 0, 0, 31, 32'h80A50001);

    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    repeat (3) @(negedge clk);

    chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err",   32'(bus.resp_err),   32'd0);
    chk("rst_resp_rdata", bus.resp_rdata,      32'h0);
    chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
    chk("rst_mem_re",     32'(bus.mem_re),     32'd0);
    chk("rst_mem_addr",   bus.mem_addr,        32'h0);
    chk("rst_mem_wdata",  bus.mem_wdata,       32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 21; i++) do_op($sformatf("v%0d", i), tbl[i]);

    // Reset asserted while an SB sits in CAPTURE: op is dropped, no write.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b1;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h09;
    bus.req_wdata    = 32'h00000077;
    @(posedge clk);
    we0 = we_cnt;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("midrst_read_re", 32'(bus.mem_re), 32'd1);
    @(negedge clk);
    chk("midrst_capture_re", 32'(bus.mem_re), 32'd0);
    chk("midrst_capture_mem_addr", bus.mem_addr, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready",  32'(bus.req_ready),  32'd1);
    chk("midrst_mem_we",     32'(bus.mem_we),     32'd0);
    chk("midrst_mem_re",     32'(bus.mem_re),     32'd0);
    chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("midrst_mem_addr",   bus.mem_addr,        32'h0);
    chk("midrst_mem_wdata",  bus.mem_wdata,       32'h0);
    seen_resp = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      if (bus.resp_valid) seen_resp++;
    end
    #1;
    chk("midrst_no_resp",   seen_resp,     32'd0);
    chk("midrst_no_we",     we_cnt - we0,  32'd0);
    chk("midrst_mem_word",  mem[2],        32'h12345500);

    do_op("post_rst_lw", mk(0, 2'b10, 0, 32'h08, 32'h0, 0, 32'h12345500, 3, 1, 0, 2, 32'h12345500));

    chk("no_re_we_overlap", overlap_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
